// File: rtl/dmem_arbiter_pkg.sv
// Shared constants for the dmem arbiter: port IDs, arbiter state encoding, default burst limit.
// Pure definitions; no logic, latency or backpressure of its own.
package dmem_arbiter_pkg;

    localparam logic PORT_P = 1'b0;
    localparam logic PORT_L = 1'b1;

    localparam int DEFAULT_MAX_BURST = 8;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/dmem_rr_pick.sv
// Two-way round-robin chooser: a lone requester wins, a tie goes to the port that did not win last.
// Purely combinational; losers see no grant and must keep requesting.
module dmem_rr_pick
    import dmem_arbiter_pkg::*;
(
    input  logic p_req,
    input  logic l_req,
    input  logic last,
    output logic pick_p,
    output logic pick_l
);

    assign pick_p = p_req && (!l_req || last == PORT_L);
    assign pick_l = l_req && (!p_req || last == PORT_P);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares single-port dmem between processor (P) and loader (L): round-robin plus bounded L burst lock.
// Grants are combinational, read data returns one cycle after grant; ungranted ports must hold requests.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = DEFAULT_MAX_BURST
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              p_req,
    input  logic [ADDR_W-1:0] p_addr,
    input  logic [DATA_W-1:0] p_wdata,
    input  logic              p_wren,
    output logic              p_gnt,
    output logic              p_rvalid,
    output logic [DATA_W-1:0] p_rdata,
    input  logic              l_req,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    input  logic              l_wren,
    input  logic              l_lock,
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic [DATA_W-1:0] l_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

    arb_state_t       state, state_nxt;
    logic             last, last_nxt;
    logic [CNT_W-1:0] burst_cnt, burst_nxt;
    logic             rd_owner;
    logic             rd_pend;

    logic rr_p, rr_l;
    logic lock_hold;
    logic any_gnt;

    dmem_rr_pick u_pick (
        .p_req  (p_req),
        .l_req  (l_req),
        .last   (last),
        .pick_p (rr_p),
        .pick_l (rr_l)
    );

    // The lock only binds while L keeps both l_req and l_lock up; otherwise fall back to round-robin.
    assign lock_hold = (state == LOCKED) && l_req && l_lock;

    always_comb begin
        p_gnt = 1'b0;
        l_gnt = 1'b0;
        if (!reset) begin
            if (lock_hold) begin
                if (burst_cnt == BURST_MAX && p_req) begin
                    p_gnt = 1'b1;
                end else begin
                    l_gnt = 1'b1;
                end
            end else begin
                p_gnt = rr_p;
                l_gnt = rr_l;
            end
        end
    end

    assign any_gnt     = p_gnt || l_gnt;
    assign mem_address = l_gnt ? l_addr  : p_addr;
    assign mem_data    = l_gnt ? l_wdata : p_wdata;
    assign mem_wren    = l_gnt ? l_wren  : (p_gnt && p_wren);

    always_comb begin
        state_nxt = state;
        burst_nxt = burst_cnt;
        last_nxt  = last;
        if (p_gnt) begin
            last_nxt = PORT_P;
        end else if (l_gnt) begin
            last_nxt = PORT_L;
        end
        if (l_gnt && l_lock) begin
            state_nxt = LOCKED;
            if (state == ARB) begin
                burst_nxt = CNT_W'(1);
            end else if (burst_cnt != BURST_MAX) begin
                burst_nxt = burst_cnt + CNT_W'(1);
            end
        end else begin
            state_nxt = ARB;
            burst_nxt = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ARB;
            last      <= PORT_L;
            burst_cnt <= '0;
            rd_pend   <= 1'b0;
            rd_owner  <= PORT_P;
        end else begin
            state     <= state_nxt;
            last      <= last_nxt;
            burst_cnt <= burst_nxt;
            rd_pend   <= any_gnt && !mem_wren;
            if (any_gnt) begin
                rd_owner <= l_gnt ? PORT_L : PORT_P;
            end
        end
    end

    assign p_rvalid = !reset && rd_pend && (rd_owner == PORT_P);
    assign l_rvalid = !reset && rd_pend && (rd_owner == PORT_L);
    assign p_rdata  = p_rvalid ? mem_q : '0;
    assign l_rdata  = l_rvalid ? mem_q : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed scenarios then held-request random traffic,
// grants checked per cycle against a rule-level model, read returns checked by a separate monitor.
module tb_dmem_arbiter;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int MB = 8;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic          reset;
    logic          p_req, p_wren, l_req, l_wren, l_lock;
    logic [AW-1:0] p_addr, l_addr;
    logic [DW-1:0] p_wdata, l_wdata;
    logic          p_gnt, p_rvalid, l_gnt, l_rvalid, mem_wren;
    logic [DW-1:0] p_rdata, l_rdata, mem_data, mem_q;
    logic [AW-1:0] mem_address;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clock(clock), .reset(reset),
        .p_req(p_req), .p_addr(p_addr), .p_wdata(p_wdata), .p_wren(p_wren),
        .p_gnt(p_gnt), .p_rvalid(p_rvalid), .p_rdata(p_rdata),
        .l_req(l_req), .l_addr(l_addr), .l_wdata(l_wdata), .l_wren(l_wren), .l_lock(l_lock),
        .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
        .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit mon_on = 1'b0;

    // Unwritten words read back as a per-address pattern so stale/wrong addresses show up.
    function automatic logic [31:0] key(input logic [AW-1:0] a);
        return {20'hA5A5A, a};
    endfunction

    bit [31:0] tmem [4096];
    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (mem_wren === 1'b1) tmem[mem_address] <= mem_data ^ key(mem_address);
        mem_q <= tmem[mem_address] ^ key(mem_address);
    end

    typedef struct {
        bit          port;
        logic [31:0] data;
        int          due;
    } rd_t;
    rd_t sb[$];

    bit        m_last;
    int        m_run;
    bit [31:0] shadow [4096];
    bit        sh_wr  [4096];
    bit        p_hold, l_hold;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clock) begin : monitor
        rd_t e;
        if (mon_on) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                chk("p_rvalid", p_rvalid, e.port == 1'b0);
                chk("l_rvalid", l_rvalid, e.port == 1'b1);
                if (e.port) begin
                    chk("l_rdata", l_rdata, e.data);
                    chk("p_rdata_idle", p_rdata, 0);
                end else begin
                    chk("p_rdata", p_rdata, e.data);
                    chk("l_rdata_idle", l_rdata, 0);
                end
            end else begin
                chk("p_rvalid_idle", p_rvalid, 0);
                chk("l_rvalid_idle", l_rvalid, 0);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic set_p(input bit r, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit w);
        p_req = r; p_addr = a; p_wdata = d; p_wren = w;
    endtask

    task automatic set_l(input bit r, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit w,
                         input bit lk);
        l_req = r; l_addr = a; l_wdata = d; l_wren = w; l_lock = lk;
    endtask

    // Predict this cycle's grant from the arbitration rules, compare, then advance the model.
    task automatic eval();
        bit ep, el, ew;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        #1;
        ep = 1'b0;
        el = 1'b0;
        if (!reset) begin
            if (m_run > 0 && l_req && l_lock) begin
                if (m_run >= MB && p_req) ep = 1'b1;
                else el = 1'b1;
            end else if (p_req && l_req) begin
                if (m_last) ep = 1'b1;
                else el = 1'b1;
            end else begin
                ep = p_req;
                el = l_req;
            end
        end
        ew = ep ? p_wren : (el ? l_wren : 1'b0);
        ea = ep ? p_addr : l_addr;
        ed = ep ? p_wdata : l_wdata;
        chk("p_gnt", p_gnt, ep);
        chk("l_gnt", l_gnt, el);
        chk("mem_wren", mem_wren, ew);
        if (ep || el) begin
            chk("mem_address", mem_address, ea);
            if (ew) chk("mem_data", mem_data, ed);
        end
        if (reset) begin
            m_last = 1'b1;
            m_run  = 0;
            sb.delete();
        end else begin
            if (ep || el) begin
                m_last = el;
                if (ew) begin
                    shadow[ea] = ed;
                    sh_wr[ea]  = 1'b1;
                end else begin
                    sb.push_back('{port: el, data: (sh_wr[ea] ? shadow[ea] : key(ea)), due: cyc + 1});
                end
            end
            if (el && l_lock) m_run = (m_run < MB) ? m_run + 1 : MB;
            else m_run = 0;
        end
        p_hold = p_req && !ep;
        l_hold = l_req && !el;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1);
    end

    initial begin
        int run, maxrun;
        m_last = 1'b1;
        m_run  = 0;
        reset  = 1'b1;
        set_p(1, 12'h020, 0, 0);
        set_l(1, 12'h030, 0, 0, 0);
        mon_on = 1'b1;

        // Reset held with both requesting, then first tie goes to P.
        repeat (2) begin next_cycle(); eval(); end
        next_cycle(); reset = 1'b0; eval();
        next_cycle(); set_p(0, 0, 0, 0); eval();

        // P write then read-back of the same word.
        next_cycle(); set_p(1, 12'h010, 32'hDEADBEEF, 1); set_l(0, 0, 0, 0, 0); eval();
        next_cycle(); set_p(1, 12'h010, 0, 0); eval();
        next_cycle(); set_p(0, 0, 0, 0); eval();

        // Both reading continuously without lock: alternating grants and returns.
        for (int k = 0; k < 8; k++) begin
            next_cycle(); set_p(1, 12'h010, 0, 0); set_l(1, AW'(12'h020 + k), 0, 0, 0); eval();
        end

        // Locked L write burst against a requesting P: at most MB consecutive L grants.
        maxrun = 0;
        run    = 0;
        for (int k = 0; k < 12; k++) begin
            next_cycle(); set_p(1, 12'h011, 0, 0); set_l(1, AW'(12'h040 + k), 32'h1000 + k, 1, 1); eval();
            if (l_gnt) run++;
            else run = 0;
            if (run > maxrun) maxrun = run;
        end
        chk("burst_len", maxrun, MB);

        // Lock dropped mid-burst: P must win the next cycle.
        next_cycle(); set_p(0, 0, 0, 0); set_l(0, 0, 0, 0, 0); eval();
        for (int k = 0; k < 10 && m_run < 3; k++) begin
            next_cycle(); set_p(1, 12'h041, 0, 0); set_l(1, 12'h050, 32'h55, 1, 1); eval();
        end
        next_cycle(); set_l(1, 12'h050, 32'h55, 1, 0); eval();
        chk("p_after_unlock", p_gnt, 1);
        next_cycle(); eval();

        // Reset right after an L read grant swallows the return.
        next_cycle(); set_p(0, 0, 0, 0); set_l(0, 0, 0, 0, 0); eval();
        next_cycle(); set_l(1, 12'h043, 0, 0, 0); eval();
        next_cycle(); reset = 1'b1; set_l(0, 0, 0, 0, 0); eval();
        next_cycle(); eval();
        next_cycle(); reset = 1'b0; set_p(1, 12'h043, 0, 0); set_l(1, 12'h044, 0, 0, 1); eval();

        // Random traffic; ungranted requesters hold their request unchanged.
        for (int k = 0; k < 600; k++) begin
            next_cycle();
            if (!p_hold)
                set_p($urandom_range(0, 3) != 0, AW'($urandom_range(0, 15)), $urandom, $urandom_range(0, 1) != 0);
            if (!l_hold)
                set_l($urandom_range(0, 3) != 0, AW'($urandom_range(0, 15)), $urandom, $urandom_range(0, 1) != 0,
                      $urandom_range(0, 3) != 0);
            eval();
        end

        next_cycle(); set_p(0, 0, 0, 0); set_l(0, 0, 0, 0, 0); eval();
        repeat (2) begin next_cycle(); eval(); end
        chk("scoreboard_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
